nco2_sched: RTL and testbench
=============================

NCO2_SCHED -- requirements
Module: nco2_sched

Interface
REQ-001 Parameter RESET_FREQ, default 32'h0000_0000: phase increment loaded into phi0/phi1 at reset.
REQ-002 Parameter SYNC_CYCLES, default 2: cycles nco_rst is held in SYNC; legal range 2..15.
REQ-003 clk_2x  in  1: single clock, the NCO double-rate clock; all logic on its rising edge.
REQ-004 rst_n  in  1: reset, asynchronous assert, active-low.
REQ-005 en  in  1: run enable; low forces the NCO idle and held in reset.
REQ-006 wr_valid  in  1: host frequency-write request.
REQ-007 wr_chan  in  1: target channel of the write (0 selects phi0, 1 selects phi1).
REQ-008 wr_freq  in  32: new phase increment.
REQ-009 wr_ready  out  1: write accepted when wr_valid and wr_ready are both high on a clock edge.
REQ-010 sync_req  in  1: single-cycle pulse requesting a phase re-synchronisation.
REQ-011 sync_done  out  1: one-cycle pulse when re-synchronisation completes.
REQ-012 upd_done  out  1: one-cycle pulse when pending writes are committed to phi0/phi1.
REQ-013 state  out  1: channel select to the NCO (0 selects phi0, 1 selects phi1).
REQ-014 phi0  out  32: committed channel-0 increment.
REQ-015 phi1  out  32: committed channel-1 increment.
REQ-016 nco_rst  out  1: active-high synchronous reset to the NCO.

Function
REQ-017 The FSM SHALL have three states: IDLE, SYNC and RUN.
REQ-018 IDLE SHALL drive nco_rst=1 and state=0, and SHALL go to SYNC on the first cycle en=1.
REQ-019 SYNC SHALL drive nco_rst=1 and state=0 for exactly SYNC_CYCLES cycles (down-counter), then go to RUN with a sync_done pulse on the transition cycle.
REQ-020 RUN SHALL drive nco_rst=0; state SHALL be 0 in the first RUN cycle and toggle every cycle thereafter.
REQ-021 sync_req=1 in RUN SHALL go to SYNC on the next edge and reload the counter; sync_req in IDLE or SYNC SHALL be ignored.
REQ-022 en=0 in any state SHALL go to IDLE on the next edge; en=0 takes priority over sync_req.
REQ-023 Each channel SHALL have a 32-bit shadow register and a pending flag; wr_ready SHALL be the combinational ~pending[wr_chan].
REQ-024 An accepted write SHALL load shadow[wr_chan] with wr_freq and set pending[wr_chan].
REQ-025 In RUN, commit SHALL occur only on edges where state==1 (end of a channel pair), so both channels change together and a pair never mixes old and new words.
REQ-026 In IDLE or SYNC, commit SHALL occur on the edge after the write is accepted.
REQ-027 On commit, every pending shadow SHALL copy to its phi output and its pending flag SHALL clear; upd_done SHALL pulse in the following cycle only if at least one channel committed.
REQ-028 A write accepted on a commit edge SHALL NOT commit on that edge; it SHALL wait for the next commit opportunity (2 cycles later in RUN).
REQ-029 Writes to a non-pending channel SHALL be accepted in every FSM state.
REQ-030 phi0 and phi1 SHALL change only on commit; no arithmetic or truncation is applied, and words pass through unmodified.

Reset
REQ-031 While rst_n=0, all of the following SHALL hold asynchronously: FSM=IDLE, nco_rst=1, state=0, phi0=phi1=RESET_FREQ, shadows=RESET_FREQ, pending=0, sync counter=0, sync_done=0, upd_done=0.
REQ-032 Reset mid-operation SHALL discard pending writes; after rst_n rises with en=1, SYNC SHALL be entered on the first edge.

Verification
REQ-033 Reset release with en=1 -> nco_rst=1 for 2 cycles; sync_done pulse; then state sequence 0,1,0,1 with nco_rst=0.
REQ-034 In RUN, write ch0=32'h0100_0000 in a state==0 cycle -> phi0 updates on the following state==1 edge, upd_done pulses once, and phi1 is unchanged.
REQ-035 Write ch1=32'hA5A5_0001, then a second ch1 write before commit -> wr_ready=0 for the second write, and phi1=32'hA5A5_0001 after commit.
REQ-036 Write ch0 and ch1 on consecutive cycles within one pair -> both phi words change on the same edge, with a single upd_done pulse.
REQ-037 sync_req in RUN -> nco_rst=1 for SYNC_CYCLES cycles, state=0, sync_done pulse, then RUN resumes with state starting at 0.
REQ-038 en=0 asserted on the same cycle as sync_req -> IDLE with nco_rst=1 and no sync_done pulse; a pending write then commits on the next edge.

Source files
------------

// File: rtl/nco2_sched.sv
// -----------------------------------------------------------------------------
// nco2_sched
//   Schedules a two-channel (ping-pong) NCO running on its double-rate clock.
//   The FSM holds the NCO in reset (IDLE/SYNC), then alternates the channel
//   select every cycle in RUN. Host frequency writes land in per-channel
//   shadow registers. They are committed to phi0/phi1 only at the end of a
//   channel pair in RUN, so the NCO never sees a pair that mixes an old word
//   with a new one. In IDLE/SYNC they are committed on the very next edge.
//
// Ports
//   clk_2x    in   NCO double-rate clock; all logic on its rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   run enable (low -> IDLE, NCO held in reset)
//   wr_valid  in   host write request
//   wr_chan   in   write target (0 -> phi0, 1 -> phi1)
//   wr_freq   in   new phase increment [31:0]
//   wr_ready  out  write accepted when wr_valid && wr_ready at an edge
//   sync_req  in   one-cycle phase re-synchronisation request (RUN only)
//   sync_done out  one-cycle pulse on the SYNC -> RUN transition cycle
//   upd_done  out  one-cycle pulse the cycle after a commit of >= 1 channel
//   state     out  channel select to the NCO
//   phi0/phi1 out  committed channel increments [31:0]
//   nco_rst   out  active-high synchronous reset to the NCO
// -----------------------------------------------------------------------------
module nco2_sched #(
   parameter logic [31:0] RESET_FREQ  = 32'h0000_0000,
   parameter int          SYNC_CYCLES = 2
) (
   input  logic        clk_2x,
   input  logic        rst_n,
   input  logic        en,
   input  logic        wr_valid,
   input  logic        wr_chan,
   input  logic [31:0] wr_freq,
   output logic        wr_ready,
   input  logic        sync_req,
   output logic        sync_done,
   output logic        upd_done,
   output logic        state,
   output logic [31:0] phi0,
   output logic [31:0] phi1,
   output logic        nco_rst
);

   localparam int          NUM_CH  = 2;
   localparam logic [3:0]  LP_SYNC = 4'(SYNC_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_RUN  = 2'd2
   } st_t;

   st_t                          r_st, w_st_nxt;
   logic [3:0]                   r_cnt, w_cnt_nxt;
   logic                         r_sel;
   logic                         w_sync_done;
   logic                         w_commit;
   logic                         w_acc;
   logic                         r_upd_done;
   logic [NUM_CH-1:0]            r_pend;
   logic [NUM_CH-1:0][31:0]      r_shadow;
   logic [NUM_CH-1:0][31:0]      r_phi;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk_2x or negedge rst_n) begin
      if (!rst_n) begin
         r_st  <= ST_IDLE;
         r_cnt <= 4'd0;
      end else begin
         r_st  <= w_st_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_st_nxt    = r_st;
      w_cnt_nxt   = r_cnt;
      w_sync_done = 1'b0;
      case (r_st)
         ST_IDLE: begin
            if (en) begin
               w_st_nxt  = ST_SYNC;
               w_cnt_nxt = LP_SYNC;
            end
         end
         ST_SYNC: begin
            // sync_req is ignored here; only en can abort the sequence
            if (!en) begin
               w_st_nxt  = ST_IDLE;
               w_cnt_nxt = 4'd0;
            end else if (r_cnt <= 4'd1) begin
               w_st_nxt    = ST_RUN;
               w_cnt_nxt   = 4'd0;
               w_sync_done = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         ST_RUN: begin
            if (!en) begin
               w_st_nxt = ST_IDLE;
            end else if (sync_req) begin
               w_st_nxt  = ST_SYNC;
               w_cnt_nxt = LP_SYNC;
            end
         end
         default: begin
            w_st_nxt  = ST_IDLE;
            w_cnt_nxt = 4'd0;
         end
      endcase
   end

   // Channel select: held at 0 outside RUN and in the first RUN cycle,
   // toggles only while RUN persists across the edge.
   always_ff @(posedge clk_2x or negedge rst_n) begin
      if (!rst_n)                                 r_sel <= 1'b0;
      else if (r_st == ST_RUN && w_st_nxt == ST_RUN) r_sel <= ~r_sel;
      else                                        r_sel <= 1'b0;
   end

   // ------------------------------------------------------- shadow/commit
   // Commit edges: end of each channel pair in RUN, every edge otherwise.
   // A write accepted on a commit edge targets a non-pending channel, so it
   // is never committed on that same edge.
   assign w_commit = (r_st == ST_RUN) ? r_sel : 1'b1;
   assign wr_ready = ~r_pend[wr_chan];
   assign w_acc    = wr_valid & wr_ready;

   always_ff @(posedge clk_2x or negedge rst_n) begin
      if (!rst_n) begin
         r_pend     <= '0;
         r_shadow   <= {NUM_CH{RESET_FREQ}};
         r_phi      <= {NUM_CH{RESET_FREQ}};
         r_upd_done <= 1'b0;
      end else begin
         r_upd_done <= w_commit & (|r_pend);
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_commit && r_pend[c]) begin
               r_phi[c]  <= r_shadow[c];
               r_pend[c] <= 1'b0;
            end
            if (w_acc && (int'(wr_chan) == c)) begin
               r_shadow[c] <= wr_freq;
               r_pend[c]   <= 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------ outputs
   assign nco_rst   = (r_st != ST_RUN);
   assign state     = r_sel;
   assign sync_done = w_sync_done;
   assign upd_done  = r_upd_done;
   assign phi0      = r_phi[0];
   assign phi1      = r_phi[1];

endmodule

// File: tb/tb_nco2_sched.sv
module tb_nco2_sched;

   localparam logic [31:0] RF = 32'h1357_9BDF;

   logic        clk_2x = 1'b0;
   logic        rst_n, en, wr_valid, wr_chan, sync_req;
   logic [31:0] wr_freq;
   logic        wr_ready, sync_done, upd_done, state, nco_rst;
   logic [31:0] phi0, phi1;

   int n_chk  = 0;
   int n_fail = 0;

   nco2_sched #(.RESET_FREQ(RF), .SYNC_CYCLES(2)) dut (
      .clk_2x(clk_2x), .rst_n(rst_n), .en(en),
      .wr_valid(wr_valid), .wr_chan(wr_chan), .wr_freq(wr_freq),
      .wr_ready(wr_ready), .sync_req(sync_req), .sync_done(sync_done),
      .upd_done(upd_done), .state(state), .phi0(phi0), .phi1(phi1),
      .nco_rst(nco_rst)
   );

   always #5 clk_2x = ~clk_2x;

   task automatic tick();
      @(posedge clk_2x);
      #1;
   endtask

   // Advance (bounded) until the channel select equals v.
   task automatic wait_sel(input logic v);
      int n = 0;
      while (state !== v && n < 4) begin tick(); n++; end
      n_chk++; if (state !== v) begin n_fail++; $display("FAIL wait_sel: state=%b want %b", state, v); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; wr_valid = 1'b0; wr_chan = 1'b0; wr_freq = '0; sync_req = 1'b0;
      #12;
      n_chk++; if (nco_rst !== 1'b1) begin n_fail++; $display("FAIL rst_nco_rst: got %b want 1", nco_rst); end
      n_chk++; if (state !== 1'b0) begin n_fail++; $display("FAIL rst_state: got %b want 0", state); end
      n_chk++; if (phi0 !== RF) begin n_fail++; $display("FAIL rst_phi0: got %h want %h", phi0, RF); end
      n_chk++; if (phi1 !== RF) begin n_fail++; $display("FAIL rst_phi1: got %h want %h", phi1, RF); end
      n_chk++; if (sync_done !== 1'b0 || upd_done !== 1'b0) begin n_fail++; $display("FAIL rst_pulses: sync_done=%b upd_done=%b want 0 0", sync_done, upd_done); end
      n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wr_ready: got %b want 1", wr_ready); end
      tick();
   endtask

   task automatic test_startup();
      logic exp_sel;
      rst_n = 1'b1; en = 1'b1;
      // IDLE cycle, then two SYNC cycles, last one carries sync_done
      n_chk++; if (nco_rst !== 1'b1 || sync_done !== 1'b0) begin n_fail++; $display("FAIL start_idle: nco_rst=%b sync_done=%b want 1 0", nco_rst, sync_done); end
      tick();
      n_chk++; if (nco_rst !== 1'b1 || state !== 1'b0 || sync_done !== 1'b0) begin n_fail++; $display("FAIL start_sync1: nco_rst=%b state=%b sync_done=%b want 1 0 0", nco_rst, state, sync_done); end
      tick();
      n_chk++; if (nco_rst !== 1'b1 || state !== 1'b0 || sync_done !== 1'b1) begin n_fail++; $display("FAIL start_sync2: nco_rst=%b state=%b sync_done=%b want 1 0 1", nco_rst, state, sync_done); end
      tick();
      exp_sel = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_chk++; if (nco_rst !== 1'b0 || state !== exp_sel || sync_done !== 1'b0) begin n_fail++; $display("FAIL start_run%0d: nco_rst=%b state=%b sync_done=%b want 0 %b 0", i, nco_rst, state, sync_done, exp_sel); end
         exp_sel = ~exp_sel;
         tick();
      end
   endtask

   task automatic test_ch0_write();
      wait_sel(1'b0);
      wr_valid = 1'b1; wr_chan = 1'b0; wr_freq = 32'h0100_0000;
      n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL ch0_ready: got %b want 1", wr_ready); end
      tick();
      wr_valid = 1'b0;
      n_chk++; if (phi0 !== RF || upd_done !== 1'b0 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL ch0_pending: phi0=%h upd=%b rdy=%b want %h 0 0", phi0, upd_done, wr_ready, RF); end
      tick();
      n_chk++; if (phi0 !== 32'h0100_0000 || upd_done !== 1'b1) begin n_fail++; $display("FAIL ch0_commit: phi0=%h upd=%b want 01000000 1", phi0, upd_done); end
      n_chk++; if (phi1 !== RF) begin n_fail++; $display("FAIL ch0_phi1_kept: got %h want %h", phi1, RF); end
      tick();
      n_chk++; if (upd_done !== 1'b0) begin n_fail++; $display("FAIL ch0_upd_once: got %b want 0", upd_done); end
   endtask

   task automatic test_ch1_double();
      wait_sel(1'b0);
      wr_valid = 1'b1; wr_chan = 1'b1; wr_freq = 32'hA5A5_0001;
      tick();
      wr_freq = 32'hDEAD_BEEF;
      n_chk++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL ch1_second_ready: got %b want 0", wr_ready); end
      tick();
      wr_valid = 1'b0;
      n_chk++; if (phi1 !== 32'hA5A5_0001 || upd_done !== 1'b1) begin n_fail++; $display("FAIL ch1_commit: phi1=%h upd=%b want a5a50001 1", phi1, upd_done); end
      n_chk++; if (phi0 !== 32'h0100_0000) begin n_fail++; $display("FAIL ch1_phi0_kept: got %h want 01000000", phi0); end
      tick(); tick(); tick();
      n_chk++; if (phi1 !== 32'hA5A5_0001) begin n_fail++; $display("FAIL ch1_dropped: phi1=%h want a5a50001", phi1); end
   endtask

   task automatic test_pair();
      wait_sel(1'b1);
      // ch0 accepted on a commit edge: must wait for the next pair end
      wr_valid = 1'b1; wr_chan = 1'b0; wr_freq = 32'h1111_2222;
      tick();
      wr_chan = 1'b1; wr_freq = 32'h3333_4444;
      n_chk++; if (phi0 !== 32'h0100_0000 || upd_done !== 1'b0) begin n_fail++; $display("FAIL pair_no_early: phi0=%h upd=%b want 01000000 0", phi0, upd_done); end
      tick();
      wr_valid = 1'b0;
      n_chk++; if (phi0 !== 32'h0100_0000 || phi1 !== 32'hA5A5_0001) begin n_fail++; $display("FAIL pair_hold: phi0=%h phi1=%h", phi0, phi1); end
      tick();
      n_chk++; if (phi0 !== 32'h1111_2222 || phi1 !== 32'h3333_4444 || upd_done !== 1'b1) begin n_fail++; $display("FAIL pair_commit: phi0=%h phi1=%h upd=%b want 11112222 33334444 1", phi0, phi1, upd_done); end
      tick();
      n_chk++; if (upd_done !== 1'b0) begin n_fail++; $display("FAIL pair_upd_once: got %b want 0", upd_done); end
   endtask

   task automatic test_sync_req();
      wait_sel(1'b0);
      sync_req = 1'b1;
      tick();
      // request during SYNC is ignored: still exactly two SYNC cycles
      n_chk++; if (nco_rst !== 1'b1 || state !== 1'b0 || sync_done !== 1'b0) begin n_fail++; $display("FAIL sync1: nco_rst=%b state=%b sync_done=%b want 1 0 0", nco_rst, state, sync_done); end
      tick();
      sync_req = 1'b0;
      n_chk++; if (nco_rst !== 1'b1 || sync_done !== 1'b1) begin n_fail++; $display("FAIL sync2: nco_rst=%b sync_done=%b want 1 1", nco_rst, sync_done); end
      tick();
      n_chk++; if (nco_rst !== 1'b0 || state !== 1'b0 || sync_done !== 1'b0) begin n_fail++; $display("FAIL sync_run0: nco_rst=%b state=%b sync_done=%b want 0 0 0", nco_rst, state, sync_done); end
      tick();
      n_chk++; if (state !== 1'b1) begin n_fail++; $display("FAIL sync_run1: state=%b want 1", state); end
   endtask

   task automatic test_en_off();
      wait_sel(1'b0);
      en = 1'b0; sync_req = 1'b1;
      wr_valid = 1'b1; wr_chan = 1'b0; wr_freq = 32'h5555_AAAA;
      tick();
      en = 1'b0; sync_req = 1'b0; wr_valid = 1'b0;
      n_chk++; if (nco_rst !== 1'b1 || state !== 1'b0 || sync_done !== 1'b0) begin n_fail++; $display("FAIL enoff_idle: nco_rst=%b state=%b sync_done=%b want 1 0 0", nco_rst, state, sync_done); end
      n_chk++; if (phi0 !== 32'h1111_2222) begin n_fail++; $display("FAIL enoff_hold: phi0=%h want 11112222", phi0); end
      tick();
      n_chk++; if (phi0 !== 32'h5555_AAAA || upd_done !== 1'b1 || sync_done !== 1'b0) begin n_fail++; $display("FAIL enoff_commit: phi0=%h upd=%b sd=%b want 5555aaaa 1 0", phi0, upd_done, sync_done); end
      wr_valid = 1'b1; wr_chan = 1'b1; wr_freq = 32'h0BAD_F00D;
      tick();
      wr_valid = 1'b0;
      n_chk++; if (phi1 !== 32'h3333_4444) begin n_fail++; $display("FAIL idle_wr_hold: phi1=%h want 33334444", phi1); end
      tick();
      n_chk++; if (phi1 !== 32'h0BAD_F00D || upd_done !== 1'b1) begin n_fail++; $display("FAIL idle_wr_commit: phi1=%h upd=%b want 0badf00d 1", phi1, upd_done); end
   endtask

   task automatic test_reset_mid();
      en = 1'b1;
      tick(); tick(); tick();
      wait_sel(1'b0);
      wr_valid = 1'b1; wr_chan = 1'b0; wr_freq = 32'h7777_7777;
      tick();
      wr_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_chk++; if (phi0 !== RF || phi1 !== RF || nco_rst !== 1'b1 || state !== 1'b0) begin n_fail++; $display("FAIL midrst_async: phi0=%h phi1=%h nco_rst=%b state=%b", phi0, phi1, nco_rst, state); end
      n_chk++; if (wr_ready !== 1'b1 || upd_done !== 1'b0) begin n_fail++; $display("FAIL midrst_pend: rdy=%b upd=%b want 1 0", wr_ready, upd_done); end
      #2;
      rst_n = 1'b1;
      tick();
      n_chk++; if (nco_rst !== 1'b1 || sync_done !== 1'b0) begin n_fail++; $display("FAIL midrst_sync1: nco_rst=%b sd=%b want 1 0", nco_rst, sync_done); end
      tick();
      n_chk++; if (sync_done !== 1'b1) begin n_fail++; $display("FAIL midrst_sync2: sd=%b want 1", sync_done); end
      tick(); tick(); tick();
      n_chk++; if (phi0 !== RF || nco_rst !== 1'b0 || upd_done !== 1'b0) begin n_fail++; $display("FAIL midrst_discard: phi0=%h nco_rst=%b upd=%b want %h 0 0", phi0, nco_rst, upd_done, RF); end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_ch0_write();
      test_ch1_double();
      test_pair();
      test_sync_req();
      test_en_off();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
